// File: rtl/addsub_pkg.sv
// Shared types and constants for the serial add/subtract unit.
// Contents: FSM state enum, operation codes, and helpers giving the signed
// saturation limits for an arbitrary width (returned zero-extended to 64 bits).
package addsub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Largest positive two's-complement value of width w: 0111...1
  function automatic logic [63:0] sat_max(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of width w: 1000...0
  function automatic logic [63:0] sat_min(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/serial_addsub_unit_if.sv
// Handshake/data bundle between the operand source and the add/sub unit.
// master: operand source / result consumer; slave: the add/sub unit.
// Signals: in_valid/in_ready/addsub/x/y (request), out_valid/out_ready/result
// and flags c_out/overflow/zero/negative (response), busy (status).
interface serial_addsub_unit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             addsub;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             overflow;
  logic             zero;
  logic             negative;
  logic             busy;

  modport master (
    output in_valid, addsub, x, y, out_ready,
    input  in_ready, out_valid, result, c_out, overflow, zero, negative, busy
  );

  modport slave (
    input  in_valid, addsub, x, y, out_ready,
    output in_ready, out_valid, result, c_out, overflow, zero, negative, busy
  );
endinterface

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full_adder cells.
// Ports: a, b (CHUNK-bit addends), c_in; sum, c_out (carry out of top bit),
// c_msb (carry into top bit, used for signed overflow on the final chunk).
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] sum,
  output logic             c_out,
  output logic             c_msb
);
  logic [CHUNK:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign c_out = c[CHUNK];
  assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/full_adder.sv
// One-bit full adder.
// Ports: a, b, ci (inputs); s (sum), co (carry out).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_addsub_unit.sv
// Multi-cycle two's-complement add/subtract unit, CHUNK bits per clock.
// Ports: clk, rst (async, active-high); bus (serial_addsub_unit_if.slave):
//   in_valid/in_ready/addsub/x/y request, out_valid/out_ready/result and
//   c_out/overflow/zero/negative response, busy status.
// Optional: define ADDSUB_SAT_EN to saturate the result on signed overflow
// (overflow and c_out still report the raw event).
module serial_addsub_unit
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_addsub_unit_if.slave  bus
);
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("serial_addsub_unit: WIDTH must be a multiple of CHUNK");
  end

`ifdef ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));
`endif

  state_t           state, state_n;
  logic             load, step, last;
  logic [CW-1:0]    count;
  logic             carry;
  logic [WIDTH-1:0] xr, yr, res, res_step, res_fin;
  logic             c_out_r, ovf_r, zero_r, neg_r;
  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic             add_cout, add_cmsb, ovf_step;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // FSM next state and datapath strobes
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    last    = (count == LAST);
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Current chunk of each operand feeds the single shared chunk adder
  always_comb begin
    a_ch = xr[count*CHUNK +: CHUNK];
    b_ch = yr[count*CHUNK +: CHUNK];
  end

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_ch),
    .b     (b_ch),
    .c_in  (carry),
    .sum   (s_ch),
    .c_out (add_cout),
    .c_msb (add_cmsb)
  );

  // Result with this cycle's chunk merged in; on the last chunk this is the
  // complete answer, from which the flags are derived before it is stored.
  always_comb begin
    res_step = res;
    res_step[count*CHUNK +: CHUNK] = s_ch;
    ovf_step = add_cmsb ^ add_cout;
    res_fin  = res_step;
`ifdef ADDSUB_SAT_EN
    if (ovf_step) res_fin = xr[WIDTH-1] ? SAT_MIN : SAT_MAX;
`endif
  end

  // Subtraction is x + ~y + 1: invert y on capture, seed the carry with 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr      <= '0;
      yr      <= '0;
      carry   <= 1'b0;
      count   <= '0;
      res     <= '0;
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
      neg_r   <= 1'b0;
    end else if (load) begin
      xr    <= bus.x;
      yr    <= bus.y ^ {WIDTH{bus.addsub}};
      carry <= (bus.addsub == OP_SUB);
      count <= '0;
    end else if (step) begin
      carry <= add_cout;
      if (last) begin
        res     <= res_fin;
        c_out_r <= add_cout;
        ovf_r   <= ovf_step;
        zero_r  <= (res_fin == '0);
        neg_r   <= res_fin[WIDTH-1];
      end else begin
        res   <= res_step;
        count <= count + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.result    = res;
  assign bus.c_out     = c_out_r;
  assign bus.overflow  = ovf_r;
  assign bus.zero      = zero_r;
  assign bus.negative  = neg_r;
endmodule

// File: tb/tb_serial_addsub_unit.sv
// Self-checking bench for serial_addsub_unit: one instance with CHUNK=4
// (four passes) and one with CHUNK=16 (single pass), WIDTH=16 for both.
// Expected results come from a plain-arithmetic reference model; a monitor
// pops them from a per-instance queue whenever a result is accepted.
module tb_serial_addsub_unit;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        drv_valid [2];
  logic        drv_sub   [2];
  logic        drv_ready [2];
  logic [15:0] drv_x     [2];
  logic [15:0] drv_y     [2];
  logic        obs_valid [2];
  logic        obs_rdy   [2];
  logic        obs_busy  [2];
  exp_t        obs_out   [2];

  exp_t q0[$];
  exp_t q1[$];

  serial_addsub_unit_if #(.WIDTH(16)) ia ();
  serial_addsub_unit_if #(.WIDTH(16)) ib ();

  serial_addsub_unit #(.WIDTH(16), .CHUNK(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  serial_addsub_unit #(.WIDTH(16), .CHUNK(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  assign ia.in_valid  = drv_valid[0];
  assign ia.addsub    = drv_sub[0];
  assign ia.x         = drv_x[0];
  assign ia.y         = drv_y[0];
  assign ia.out_ready = drv_ready[0];
  assign ib.in_valid  = drv_valid[1];
  assign ib.addsub    = drv_sub[1];
  assign ib.x         = drv_x[1];
  assign ib.y         = drv_y[1];
  assign ib.out_ready = drv_ready[1];

  assign obs_valid[0] = ia.out_valid;
  assign obs_rdy[0]   = ia.in_ready;
  assign obs_busy[0]  = ia.busy;
  assign obs_out[0]   = {ia.result, ia.c_out, ia.overflow, ia.zero, ia.negative};
  assign obs_valid[1] = ib.out_valid;
  assign obs_rdy[1]   = ib.in_ready;
  assign obs_busy[1]  = ib.busy;
  assign obs_out[1]   = {ib.result, ib.c_out, ib.overflow, ib.zero, ib.negative};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nch(input int s);
    return (s == 0) ? 4 : 1;
  endfunction

  // Reference: signed/unsigned integer arithmetic on the operand values
  function automatic exp_t model(input logic sub, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   sa;
    int   sb;
    int   sum;
    int   ua;
    int   ub;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = int'(a);
    ub  = int'(b);
    sum = sub ? (sa - sb) : (sa + sb);
    e.r = sub ? (a - b) : (a + b);
    e.c = sub ? (ua >= ub) : (ua + ub > 65535);
    e.v = (sum > 32767) || (sum < -32768);
`ifdef ADDSUB_SAT_EN
    if (e.v) e.r = (sum > 0) ? 16'h7FFF : 16'h8000;
`endif
    e.z = (e.r == 16'h0000);
    e.n = e.r[15];
    return e;
  endfunction

  // Monitor: compare on every accepted result
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (obs_valid[i] && drv_ready[i]) begin
          if (i == 0) begin
            chk("a_queue_nonempty", 32'(q0.size() != 0), 1);
            if (q0.size() != 0) chk("a_result_flags", 32'(obs_out[0]), 32'(q0.pop_front()));
          end else begin
            chk("b_queue_nonempty", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) chk("b_result_flags", 32'(obs_out[1]), 32'(q1.pop_front()));
          end
        end
      end
    end
  end

  // Inputs change #1 after the rising edge; the monitor samples on the falling edge.
  task automatic wait_ready(input int s, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!obs_rdy[s] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(obs_rdy[s]), 1);
    ok = obs_rdy[s];
  endtask

  task automatic op(input int s, input logic sub, input logic [15:0] a, input logic [15:0] b, input int hold);
    exp_t e;
    bit   ok;
    int   lat;
    drv_x[s]     = a;
    drv_y[s]     = b;
    drv_sub[s]   = sub;
    drv_valid[s] = 1'b1;
    drv_ready[s] = 1'b0;
    wait_ready(s, ok);
    if (!ok) begin
      drv_valid[s] = 1'b0;
      return;
    end
    @(posedge clk);
    e = model(sub, a, b);
    if (s == 0) q0.push_back(e); else q1.push_back(e);
    #1;
    drv_valid[s] = 1'b0;
    drv_x[s]     = 16'($urandom);
    drv_y[s]     = 16'($urandom);
    drv_sub[s]   = ~sub;
    chk("busy_run", 32'(obs_busy[s]), 1);
    lat = 1;
    while (!obs_valid[s] && lat < 40) begin
      @(posedge clk);
      #1;
      if (!obs_valid[s]) lat++;
    end
    chk("latency", 32'(lat), 32'(nch(s)));
    for (int k = 0; k < hold; k++) begin
      drv_valid[s] = (k % 2 == 0);
      @(posedge clk);
      #1;
      chk("hold_outputs", 32'(obs_out[s]), 32'(e));
      chk("hold_in_ready", 32'(obs_rdy[s]), 0);
      chk("hold_out_valid", 32'(obs_valid[s]), 1);
    end
    drv_valid[s] = 1'b0;
    drv_ready[s] = 1'b1;
    @(posedge clk);
    #1;
    drv_ready[s] = 1'b0;
    chk("in_ready_after", 32'(obs_rdy[s]), 1);
    chk("out_valid_drop", 32'(obs_valid[s]), 0);
  endtask

  task automatic rst_test(input int s);
    bit ok;
    bit seen;
    drv_x[s]     = 16'hAAAA;
    drv_y[s]     = 16'h5555;
    drv_sub[s]   = 1'b0;
    drv_valid[s] = 1'b1;
    drv_ready[s] = 1'b1;
    wait_ready(s, ok);
    @(posedge clk);
    #1;
    drv_valid[s] = 1'b0;
    if (nch(s) > 1) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(obs_valid[s]), 0);
    chk("rst_in_ready", 32'(obs_rdy[s]), 0);
    chk("rst_busy", 32'(obs_busy[s]), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 32'(obs_rdy[s]), 1);
    seen = 1'b0;
    repeat (nch(s) + 3) begin
      @(posedge clk);
      #1;
      if (obs_valid[s]) seen = 1'b1;
    end
    chk("no_valid_after_rst", 32'(seen), 0);
    drv_ready[s] = 1'b0;
    op(s, 1'b0, 16'h1234, 16'h1111, 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      drv_valid[i] = 1'b0;
      drv_sub[i]   = 1'b0;
      drv_ready[i] = 1'b0;
      drv_x[i]     = '0;
      drv_y[i]     = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_outputs", 32'(obs_out[i]), 0);
      chk("reset_out_valid", 32'(obs_valid[i]), 0);
      chk("reset_in_ready", 32'(obs_rdy[i]), 0);
      chk("reset_busy", 32'(obs_busy[i]), 0);
    end
    rst = 1'b0;
    #1;
    chk("in_ready_first_cycle", 32'(obs_rdy[0]), 1);

    for (int s = 0; s < 2; s++) begin
      op(s, 1'b0, 16'h7FFF, 16'h0001, 0);
      op(s, 1'b1, 16'h0005, 16'h0005, 0);
      op(s, 1'b1, 16'h0003, 16'h0005, 0);
      op(s, 1'b1, 16'h8000, 16'h0001, 0);
      op(s, 1'b0, 16'h8000, 16'h8000, 0);
      op(s, 1'b0, 16'hFFFF, 16'h0001, 0);
      op(s, 1'b0, 16'h1234, 16'h4321, 3);
      rst_test(s);
      for (int k = 0; k < ((s == 0) ? 40 : 20); k++)
        op(s, 1'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
    end

    repeat (2) @(posedge clk);
    chk("a_queue_drained", 32'(q0.size()), 0);
    chk("b_queue_drained", 32'(q1.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
